// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RV32M/RV64M multiply/divide unit sitting beside the EX-stage ALU.
//   One operation is accepted at a time. busy is high while the operation runs,
//   so the hazard logic holds the front of the pipeline. When the operation
//   finishes, valid pulses for one cycle with result and out_reg_d.
//
// Parameters
//   XLEN        operand/result width (32 or 64)
//   MUL_LATENCY cycles from the accept edge to valid for multiplies (1..4)
//   EARLY_OUT   1: divide-by-zero and signed overflow finish in 1 cycle;
//               0: they run the full XLEN+1 cycle divide
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   stop       freeze all state and outputs (pipeline pause)
//   bubble     flush: abort the in-flight operation and clear the outputs
//   start      request a new operation (sampled only in IDLE/DONE)
//   funct3     MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU (000..111)
//   data_0     rs1 / dividend
//   data_1     rs2 / divisor
//   in_reg_d   destination register of the request
//   busy       operation in flight (MUL or DIV state)
//   valid      one-cycle result strobe (DONE state)
//   out_reg_d  destination register of the result
//   result     result value, held until the next DONE, bubble or reset
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int EARLY_OUT   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stop,
  input  logic            bubble,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data_0,
  input  logic [XLEN-1:0] data_1,
  input  logic [4:0]      in_reg_d,
  output logic            busy,
  output logic            valid,
  output logic [4:0]      out_reg_d,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;          // funct3[1:0] of the accepted operation
  logic [XLEN-1:0] opa_q, opa_d;        // multiplicand, or dividend magnitude shifting into quotient
  logic [XLEN-1:0] opb_q, opb_d;        // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;        // partial remainder
  logic            qneg_q, qneg_d;      // quotient must be negated at the end
  logic            rneg_q, rneg_d;      // remainder must be negated at the end
  logic            spec_q, spec_d;      // divide-by-zero or overflow in the full-length path
  logic [XLEN-1:0] spec_res_q, spec_res_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic [XLEN-1:0] result_q, result_d;

  // ---------------------------------------------------------------------------
  // Request decode, evaluated on the input ports at the accept edge
  // ---------------------------------------------------------------------------
  logic            in_signed, in_a_neg, in_b_neg, in_zero, in_ovf, in_special;
  logic [XLEN-1:0] in_spec_res, in_mag_a, in_mag_b;

  assign in_signed  = ~funct3[0];                 // DIV and REM are signed
  assign in_a_neg   = in_signed & data_0[XLEN-1];
  assign in_b_neg   = in_signed & data_1[XLEN-1];
  assign in_zero    = (data_1 == '0);
  assign in_ovf     = in_signed && (data_0 == MOST_NEG) && (data_1 == '1);
  assign in_special = in_zero | in_ovf;
  // RISC-V defined results: /0 gives all ones (quotient) or the dividend
  // (remainder); MOST_NEG/-1 gives MOST_NEG (quotient) or 0 (remainder).
  assign in_spec_res = in_zero ? (funct3[1] ? data_0 : '1)
                               : (funct3[1] ? '0 : MOST_NEG);
  // Negating MOST_NEG wraps to itself, which is the right unsigned magnitude.
  assign in_mag_a = in_a_neg ? -data_0 : data_0;
  assign in_mag_b = in_b_neg ? -data_1 : data_1;

  // ---------------------------------------------------------------------------
  // Multiplier: one 2*XLEN product. Operands come from the ports at the accept
  // edge (needed when MUL_LATENCY is 1) and from the latched copies in MUL.
  // ---------------------------------------------------------------------------
  logic [1:0]        mul_op;
  logic [XLEN-1:0]   mul_a, mul_b, mul_res;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] prod;

  assign mul_op = (state_q == S_MUL) ? op_q  : funct3[1:0];
  assign mul_a  = (state_q == S_MUL) ? opa_q : data_0;
  assign mul_b  = (state_q == S_MUL) ? opb_q : data_1;
  assign mul_sa = (mul_op != 2'b11);              // rs1 signed except MULHU
  assign mul_sb = ~mul_op[1];                     // rs2 signed for MUL/MULH only
  // Sign-extending both operands to 2*XLEN makes a plain modular multiply
  // produce the correct signed/unsigned/mixed product.
  assign prod = {{XLEN{mul_sa & mul_a[XLEN-1]}}, mul_a} *
                {{XLEN{mul_sb & mul_b[XLEN-1]}}, mul_b};
  assign mul_res = (mul_op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // ---------------------------------------------------------------------------
  // Restoring divider step on magnitudes. The XLEN+1 bit difference exposes
  // the borrow, which decides the quotient bit.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_sh, diff;
  logic            no_borrow;
  logic [XLEN-1:0] rem_nx, quot_nx, div_res;

  assign rem_sh    = {rem_q, opa_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, opb_q};
  assign no_borrow = ~diff[XLEN];
  assign rem_nx    = no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_nx   = {opa_q[XLEN-2:0], no_borrow};
  // Sign fix-up is applied on the edge that enters DONE.
  assign div_res   = spec_q   ? spec_res_q :
                     op_q[1]  ? (rneg_q ? -rem_nx  : rem_nx)
                              : (qneg_q ? -quot_nx : quot_nx);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a hold default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    rd_d       = rd_q;
    out_rd_d   = out_rd_q;
    result_d   = result_q;

    if (bubble) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
      out_rd_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_d = funct3[1:0];
            rd_d = in_reg_d;
            if (!funct3[2]) begin
              opa_d = data_0;
              opb_d = data_1;
              if (MUL_LATENCY == 1) begin
                state_d  = S_DONE;
                result_d = mul_res;
                out_rd_d = in_reg_d;
              end else begin
                state_d = S_MUL;
                cnt_d   = CW'(MUL_LATENCY - 2);
              end
            end else begin
              opa_d      = in_mag_a;
              opb_d      = in_mag_b;
              rem_d      = '0;
              qneg_d     = in_a_neg ^ in_b_neg;
              rneg_d     = in_a_neg;
              spec_d     = in_special;
              spec_res_d = in_spec_res;
              if ((EARLY_OUT != 0) && in_special) begin
                state_d  = S_DONE;
                result_d = in_spec_res;
                out_rd_d = in_reg_d;
              end else begin
                state_d = S_DIV;
                cnt_d   = CW'(XLEN - 1);
              end
            end
          end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = mul_res;
            out_rd_d = rd_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          opa_d = quot_nx;
          rem_d = rem_nx;
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = div_res;
            out_rd_d = rd_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. stop freezes everything, including the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      rd_q       <= '0;
      out_rd_q   <= '0;
      result_q   <= '0;
    end else if (!stop) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rem_q      <= rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      rd_q       <= rd_d;
      out_rd_q   <= out_rd_d;
      result_q   <= result_d;
    end
  end

  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign valid     = (state_q == S_DONE);
  assign out_reg_d = out_rd_q;
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Drives two copies of muldiv_unit from the same inputs: dut_fast with
//   EARLY_OUT=1 and dut_slow with EARLY_OUT=0. Expected results come from a
//   plain-arithmetic RISC-V M-extension model; expected latencies come from the
//   timing rules (MUL_LATENCY, XLEN+1, or 1 for early-out special cases).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 2;
  localparam int BUDGET      = 45;

  logic            clk = 1'b0;
  logic            reset, stop, bubble, start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data_0, data_1;
  logic [4:0]      in_reg_d;
  logic            busy_f, valid_f, busy_s, valid_s;
  logic [4:0]      rd_f, rd_s;
  logic [XLEN-1:0] res_f, res_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY), .EARLY_OUT(1)) dut_fast (
    .clk(clk), .reset(reset), .stop(stop), .bubble(bubble), .start(start),
    .funct3(funct3), .data_0(data_0), .data_1(data_1), .in_reg_d(in_reg_d),
    .busy(busy_f), .valid(valid_f), .out_reg_d(rd_f), .result(res_f)
  );

  muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY), .EARLY_OUT(0)) dut_slow (
    .clk(clk), .reset(reset), .stop(stop), .bubble(bubble), .start(start),
    .funct3(funct3), .data_0(data_0), .data_1(data_1), .in_reg_d(in_reg_d),
    .busy(busy_s), .valid(valid_s), .out_reg_d(rd_s), .result(res_s)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    int          ia, ib;
    logic [63:0] p;
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'b000: begin p = 64'(longint'(ia) * longint'(ib)); return p[31:0];  end
      3'b001: begin p = 64'(longint'(ia) * longint'(ib)); return p[63:32]; end
      3'b010: begin p = 64'(longint'(ia) * longint'(b));  return p[63:32]; end
      3'b011: begin p = 64'(longint'(a)  * longint'(b));  return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b, input bit early);
    bit special;
    if (!f3[2]) return MUL_LATENCY;
    special = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (early && special) ? 1 : XLEN + 1;
  endfunction

  // ---------------------------------------------------------------------------
  // One operation on both DUTs. Latency k means valid is seen on the k-th
  // falling edge after the accepting rising edge.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res,
                        input int lat_f, input int lat_s, input string name);
    int          seen_f, seen_s, pulses, busy_cnt;
    logic [31:0] got_f, got_s;
    logic [4:0]  grd_f, grd_s;
    seen_f = 0; seen_s = 0; pulses = 0; busy_cnt = 0;
    got_f = '0; got_s = '0; grd_f = '0; grd_s = '0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; data_0 = a; data_1 = b; in_reg_d = rd;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Inputs must not matter once the request is latched.
        start = 1'b0; funct3 = 3'($urandom); data_0 = $urandom; data_1 = $urandom;
        in_reg_d = 5'($urandom);
      end
      if (busy_f) busy_cnt++;
      if (valid_f) begin
        pulses++;
        if (seen_f == 0) begin seen_f = k; got_f = res_f; grd_f = rd_f; end
      end
      if (valid_s && seen_s == 0) begin seen_s = k; got_s = res_s; grd_s = rd_s; end
    end
    checks++; if (seen_f !== lat_f) begin failures++;
      $display("FAIL %s fast_latency got=%0d exp=%0d", name, seen_f, lat_f); end
    checks++; if (got_f !== exp_res) begin failures++;
      $display("FAIL %s fast_result got=%h exp=%h", name, got_f, exp_res); end
    checks++; if (grd_f !== rd) begin failures++;
      $display("FAIL %s fast_out_reg_d got=%0d exp=%0d", name, grd_f, rd); end
    checks++; if (busy_cnt !== lat_f - 1) begin failures++;
      $display("FAIL %s fast_busy_cycles got=%0d exp=%0d", name, busy_cnt, lat_f - 1); end
    checks++; if (pulses !== 1) begin failures++;
      $display("FAIL %s fast_valid_pulses got=%0d exp=1", name, pulses); end
    checks++; if (seen_s !== lat_s) begin failures++;
      $display("FAIL %s slow_latency got=%0d exp=%0d", name, seen_s, lat_s); end
    checks++; if (got_s !== exp_res) begin failures++;
      $display("FAIL %s slow_result got=%h exp=%h", name, got_s, exp_res); end
    checks++; if (grd_s !== rd) begin failures++;
      $display("FAIL %s slow_out_reg_d got=%0d exp=%0d", name, grd_s, rd); end
    checks++; if (res_f !== exp_res || res_s !== exp_res) begin failures++;
      $display("FAIL %s result_hold got=%h/%h exp=%h", name, res_f, res_s, exp_res); end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; stop = 1'b0; bubble = 1'b0; start = 1'b0;
    funct3 = '0; data_0 = '0; data_1 = '0; in_reg_d = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_f, valid_f, rd_f, res_f, busy_s, valid_s, rd_s, res_s} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b valid=%b rd=%0d res=%h / busy=%b valid=%b rd=%0d res=%h exp all 0",
               busy_f, valid_f, rd_f, res_f, busy_s, valid_s, rd_s, res_s);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2, 2, "mulh_minmin");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 2, 2, "mulhsu_ones");
    run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 2, 2, "mul_7_m3");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5, 32'hFFFF_FFFD, 33, 33, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF, 33, 33, "rem_m7_2");
    run_op(3'b101, 32'hFFFF_FFFF, 32'd16,        5'd7, 32'h0FFF_FFFF, 33, 33, "divu_16");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, 33, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 1, 33, "rem_ovf");
    run_op(3'b101, 32'd9,         32'd0,         5'd10, 32'hFFFF_FFFF, 1, 33, "divu_zero");
    run_op(3'b111, 32'd9,         32'd0,         5'd11, 32'd9,         1, 33, "remu_zero");
  endtask

  task automatic test_random();
    logic [31:0] edge_vals [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] a, b;
    logic [2:0]  f3;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      run_op(f3, a, b, 5'($urandom), model_result(f3, a, b),
             model_latency(f3, a, b, 1'b1), model_latency(f3, a, b, 1'b0), "random");
    end
  endtask

  task automatic test_stop_and_ignored_start();
    logic [31:0] a, b, exp_res;
    logic [2:0]  f3;
    int          seen_f, seen_s, busy_cnt;
    logic [31:0] got_f, got_s;
    f3 = $urandom_range(0, 1) ? 3'b100 : 3'b110;
    a  = $urandom;
    b  = {1'b0, 31'($urandom)} | 32'd2;          // positive, non-zero, not -1
    exp_res = model_result(f3, a, b);
    seen_f = 0; seen_s = 0; busy_cnt = 0; got_f = '0; got_s = '0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; data_0 = a; data_1 = b; in_reg_d = 5'd12;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (k >= 10 && k < 15);
      if (k == 20) begin
        start = 1'b1; funct3 = 3'b000; data_0 = $urandom; data_1 = $urandom; in_reg_d = 5'd30;
      end
      if (k == 21) begin
        checks++; if (busy_f !== 1'b1) begin failures++;
          $display("FAIL ignored_start busy got=%b exp=1", busy_f); end
      end
      if (busy_f) busy_cnt++;
      if (valid_f && seen_f == 0) begin seen_f = k; got_f = res_f; end
      if (valid_s && seen_s == 0) begin seen_s = k; got_s = res_s; end
    end
    checks++; if (seen_f !== 38 || seen_s !== 38) begin failures++;
      $display("FAIL stop_latency got=%0d/%0d exp=38", seen_f, seen_s); end
    checks++; if (got_f !== exp_res || got_s !== exp_res) begin failures++;
      $display("FAIL stop_result got=%h/%h exp=%h", got_f, got_s, exp_res); end
    checks++; if (busy_cnt !== 37) begin failures++;
      $display("FAIL stop_busy_cycles got=%0d exp=37", busy_cnt); end
    checks++; if (rd_f !== 5'd12) begin failures++;
      $display("FAIL stop_out_reg_d got=%0d exp=12", rd_f); end
  endtask

  task automatic test_bubble();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; data_0 = 32'd1000; data_1 = 32'd7; in_reg_d = 5'd13;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = 1'b0; bubble = 1'b0;
      if (k == 3) begin
        bubble = 1'b1; start = 1'b1; funct3 = 3'b000;
      end
      if (k == 4) begin
        checks++;
        if ({busy_f, valid_f, rd_f, res_f, busy_s, valid_s, rd_s, res_s} !== '0) begin
          failures++;
          $display("FAIL bubble_clear got busy=%b valid=%b rd=%0d res=%h / busy=%b valid=%b rd=%0d res=%h exp all 0",
                   busy_f, valid_f, rd_f, res_f, busy_s, valid_s, rd_s, res_s);
        end
      end
      if (valid_f || valid_s) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++;
      $display("FAIL bubble_no_valid got=%0d pulses exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    int          found;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = model_result(3'b000, a1, b1);
    e2 = model_result(3'b011, a2, b2);
    found = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; data_0 = a1; data_1 = b1; in_reg_d = 5'd14;
    for (int k = 1; k <= 10 && found == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid_f) found = k;
    end
    checks++; if (found !== MUL_LATENCY || res_f !== e1) begin failures++;
      $display("FAIL b2b_first got lat=%0d res=%h exp lat=%0d res=%h", found, res_f, MUL_LATENCY, e1); end
    start = 1'b1; funct3 = 3'b011; data_0 = a2; data_1 = b2; in_reg_d = 5'd15;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy_f !== 1'b1 || busy_s !== 1'b1) begin failures++;
      $display("FAIL b2b_accept busy got=%b/%b exp=1", busy_f, busy_s); end
    @(negedge clk);
    checks++; if (valid_f !== 1'b1 || res_f !== e2 || rd_f !== 5'd15 || valid_s !== 1'b1 || res_s !== e2) begin
      failures++;
      $display("FAIL b2b_second got valid=%b/%b res=%h/%h rd=%0d exp valid=1 res=%h rd=15",
               valid_f, valid_s, res_f, res_s, rd_f, e2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] a, b;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b001; data_0 = $urandom; data_1 = $urandom; in_reg_d = 5'd16;
    @(posedge clk);
    #1;
    checks++; if (busy_f !== 1'b1) begin failures++;
      $display("FAIL areset_mid_mul busy got=%b exp=1", busy_f); end
    #1;
    reset = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({busy_f, valid_f, rd_f, res_f, busy_s, valid_s, rd_s, res_s} !== '0) begin
      failures++;
      $display("FAIL areset_clear got busy=%b valid=%b rd=%0d res=%h / busy=%b valid=%b rd=%0d res=%h exp all 0",
               busy_f, valid_f, rd_f, res_f, busy_s, valid_s, rd_s, res_s);
    end
    @(negedge clk);
    reset = 1'b1;
    a = $urandom; b = $urandom;
    run_op(3'b000, a, b, 5'd17, model_result(3'b000, a, b), MUL_LATENCY, MUL_LATENCY, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stop_and_ignored_start();
    test_bubble();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised RV32M/RV64M multiply-divide unit in the EX stage, alongside the single-cycle ALU.
- Executes the ex_command[5:3]==3'b011 class: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Multi-cycle: asserts busy so the hazard logic holds the front of the pipeline, then emits one result with its destination register.
- Pipeline controls (stop, bubble) have the same meaning as on the rest of EX.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_LATENCY, 2, cycles from accept to valid for multiplies (1..4).
- EARLY_OUT, 1, 1 = divide-by-zero and signed overflow finish in 1 cycle; 0 = full XLEN+1 cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stop  in  1  freeze all state (pipeline pause).
- bubble  in  1  flush: abort the current operation.
- start  in  1  request a new operation.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data_0  in  XLEN  rs1 / dividend.
- data_1  in  XLEN  rs2 / divisor.
- in_reg_d  in  5  destination register.
- busy  out  1  operation in flight.
- valid  out  1  one-cycle result strobe.
- out_reg_d  out  5  destination for result.
- result  out  XLEN  result value.

Behaviour:
- Priority: reset low > stop > bubble > normal.
- Reset (asynchronous, any state, including mid-operation): state IDLE; busy=0, valid=0, out_reg_d=0, result=0; internal counters and accumulators cleared.
- FSM states: IDLE, MUL, DIV, DONE. busy=1 exactly in MUL and DIV. valid=1 exactly in DONE.
- Accept rule: start is sampled only in IDLE or DONE; a DONE->accept transition is allowed back-to-back. start in MUL/DIV is ignored (the pipeline must hold it via busy). On accept, funct3, operands and in_reg_d are latched; the input ports are not used after that.
- IDLE/DONE + start: funct3[2]=0 -> MUL; funct3[2]=1 -> DIV (or straight to DONE if it is a special case with EARLY_OUT=1). Without start, DONE -> IDLE.
- Multiply:
  - Full 2*XLEN product; signedness per funct3. MULHSU: data_0 signed, data_1 unsigned.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - valid is asserted MUL_LATENCY cycles after the accept edge.
- Divide:
  - Restoring, 1 quotient bit per cycle on magnitudes, XLEN iterations, then 1 sign-fixup cycle. valid is asserted XLEN+1 cycles after the accept edge.
  - Signs: quotient negative iff operand signs differ (DIV); remainder takes the sign of the dividend (REM).
- Special cases (bit-exact, RISC-V):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Overflow (DIV/REM with most-negative / -1): DIV -> most-negative; REM -> 0.
  - With EARLY_OUT=1 these are valid 1 cycle after accept; with EARLY_OUT=0 they use the full iteration but still produce the same results.
- result and out_reg_d update only on entry to DONE and hold until the next DONE, bubble or reset. out_reg_d=0 is computed normally; the writeback stage discards it.
- stop: state, counter, accumulators and all outputs hold. Each stop cycle extends the latency by 1. A start arriving during stop is not accepted.
- bubble (stop=0): go to IDLE. busy=0, valid=0, result=0, out_reg_d=0. The in-flight operation is lost; start in the same cycle is ignored.
- Width rules:
  - Shift counter is $clog2(XLEN)+1 bits.
  - Remainder datapath is XLEN+1 bits for the subtract borrow.
  - Negation of the most-negative value wraps, which is correct modulo 2^XLEN.

Test Plan:
- MULH 0x80000000 x 0x80000000 (XLEN=32, MUL_LATENCY=2) -> valid 2 cycles after accept, result 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 7 x -3 -> 0xFFFFFFEB.
- DIV -7/2 rd=5 -> busy for 32 cycles, valid 33 cycles after accept, result 0xFFFFFFFD, out_reg_d=5; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF.
- DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, both valid 1 cycle after accept (EARLY_OUT=1); DIVU 9/0 -> 0xFFFFFFFF and REMU 9/0 -> 9; repeat with EARLY_OUT=0 -> same values at 33 cycles.
- stop held for 5 cycles during cycle 10 of a DIV -> valid at 38 cycles with a correct result; start asserted during DIV -> ignored, busy stays 1.
- bubble during cycle 3 of a DIV -> next cycle busy=0, valid never pulses, result=0; back-to-back start in DONE -> second op accepted with no idle cycle.
- reset driven low asynchronously mid-MUL (between clock edges) -> busy, valid, result and out_reg_d go to 0 immediately; after release, a new MUL completes normally.
